// File: rtl/ff_array_pkg.sv
// Shared types for the flip-flop register array: error codes reported on err_code.
package ff_array_pkg;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_WR_OOR    = 2'd1,
      ERR_RD_OOR    = 2'd2,
      ERR_RD_UNINIT = 2'd3
   } err_code_e;

endpackage

// File: rtl/ff_array_entry.sv
// One storage word with per-byte write enables and a valid bit set by any enabled byte.
module ff_array_entry #(
   parameter int WIDTH = 8,
   parameter int NB    = WIDTH / 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sel_i,
   input  logic [NB-1:0]    be_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;

   // NOTE: combinational next-state uses blocking assignments with defaults first, so no latch is inferred.
   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      if (sel_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) word_d[8*b +: 8] = data_i[8*b +: 8];
         end
         valid_d = valid_q | (|be_i);
      end
   end

   // NOTE: storage is deliberately reset here; users rely on fully-cleared contents after reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_o  = word_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ff_array_2p.sv
// Directly-addressed register array: independent write and read ports, registered read,
// optional write-to-read bypass and a sticky first-error report.
module ff_array_2p
   import ff_array_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter bit BYPASS = 1'b1,
   parameter int NB     = WIDTH / 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [NB-1:0]    wr_be,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_vld,
   output logic             err,
   output logic [1:0]       err_code,
   input  logic             err_clr
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic             wr_ok, rd_ok, collide;
   logic [WIDTH-1:0] words [DEPTH];
   logic [DEPTH-1:0] valids;

   assign wr_ok   = {1'b0, wr_addr} < DEPTH_L;
   assign rd_ok   = {1'b0, rd_addr} < DEPTH_L;
   assign collide = wr_en & rd_en & wr_ok & rd_ok & (wr_addr == rd_addr);

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      ff_array_entry #(.WIDTH(WIDTH), .NB(NB)) u_entry (
         .clk     (clk),
         .resetn  (resetn),
         .sel_i   (wr_en && wr_ok && (wr_addr == AW'(e))),
         .be_i    (wr_be),
         .data_i  (wr_data),
         .word_o  (words[e]),
         .valid_o (valids[e])
      );
   end

   logic [WIDTH-1:0] old_word, rd_word;
   logic             old_valid, rd_valid;

   // Read mux; out-of-range addresses select nothing and read as an invalid zero word.
   always_comb begin
      old_word  = '0;
      old_valid = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         if (rd_addr == AW'(e)) begin
            old_word  = words[e];
            old_valid = valids[e];
         end
      end
      rd_word  = old_word;
      rd_valid = old_valid;
      if (BYPASS && collide) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
         end
         rd_valid = old_valid | (|wr_be);
      end
   end

   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_vld_q, rd_vld_d;
   logic             err_q, err_d;
   err_code_e        code_q, code_d, new_code;
   logic             new_err;

   always_comb begin
      rd_vld_d  = rd_en & rd_ok;
      rd_data_d = (rd_vld_d && rd_valid) ? rd_word : '0;

      new_err  = 1'b1;
      new_code = ERR_NONE;
      if (wr_en && !wr_ok)               new_code = ERR_WR_OOR;
      else if (rd_en && !rd_ok)          new_code = ERR_RD_OOR;
      else if (rd_en && rd_ok && !rd_valid) new_code = ERR_RD_UNINIT;
      else                               new_err  = 1'b0;

      err_d  = err_q;
      code_d = code_q;
      if (err_clr) begin
         err_d  = 1'b0;
         code_d = ERR_NONE;
      end
      // First error is kept until cleared; a clear in the same cycle lets the new code in.
      if (new_err) begin
         err_d = 1'b1;
         if (!err_q || err_clr) code_d = new_code;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_vld   = rd_vld_q;
   assign err      = err_q;
   assign err_code = code_q;

endmodule

// File: tb/tb_ff_array_2p.sv
// Two instances (bypass on / off, WIDTH=32, DEPTH=6) share directed stimulus;
// expected reads are queued per instance and popped by monitors on rd_vld.
module tb_ff_array_2p;

   localparam int W  = 32;
   localparam int D  = 6;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          wr_en, rd_en, err_clr;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [W-1:0]  wr_data;
   logic [3:0]    wr_be;

   logic [W-1:0]  rd_data_a, rd_data_b;
   logic          rd_vld_a, rd_vld_b, err_a, err_b;
   logic [1:0]    code_a, code_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   always #5 clk = ~clk;

   ff_array_2p #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dut_a (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a), .rd_vld(rd_vld_a),
      .err(err_a), .err_code(code_a), .err_clr(err_clr)
   );

   ff_array_2p #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0)) dut_b (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_vld(rd_vld_b),
      .err(err_b), .err_code(code_b), .err_clr(err_clr)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: every presented read result must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rd_vld_a) begin
         if (qa.size() == 0) check("a_unexpected_rd_vld", 32'd1, 32'd0);
         else check("a_rd_data", rd_data_a, qa.pop_front());
      end
      if (rd_vld_b) begin
         if (qb.size() == 0) check("b_unexpected_rd_vld", 32'd1, 32'd0);
         else check("b_rd_data", rd_data_b, qb.pop_front());
      end
   end

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
      rd_en = 1'b1; rd_addr = a;
      qa.push_back(exp_a);
      qb.push_back(exp_b);
   endtask

   task automatic check_err(input string name, input logic e, input logic [1:0] code);
      check({name, "_err_a"},  {31'd0, err_a},  {31'd0, e});
      check({name, "_err_b"},  {31'd0, err_b},  {31'd0, e});
      check({name, "_code_a"}, {30'd0, code_a}, {30'd0, code});
      check({name, "_code_b"}, {30'd0, code_b}, {30'd0, code});
   endtask

   initial begin
      idle();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_data_a", rd_data_a, 32'd0);
      check("reset_rd_vld_a", {31'd0, rd_vld_a}, 32'd0);
      check_err("reset", 1'b0, 2'd0);
      resetn = 1'b1;

      // T1: read of a never-written entry
      rd(3'd3, 32'd0, 32'd0); tick();
      check_err("t1_uninit", 1'b1, 2'd3);
      err_clr = 1'b1; tick();
      check_err("t1_clear", 1'b0, 2'd0);

      // T2: partial byte update
      wr(3'd2, 32'hAABBCCDD, 4'b1111); tick();
      wr(3'd2, 32'h00001100, 4'b0010); tick();
      rd(3'd2, 32'hAABB11DD, 32'hAABB11DD); tick();
      check_err("t2", 1'b0, 2'd0);

      // T3: same-address collision, bypass vs old data
      wr(3'd5, 32'h11223344, 4'b1111); tick();
      wr(3'd5, 32'hFF000000, 4'b1000);
      rd(3'd5, 32'hFF223344, 32'h11223344); tick();
      rd(3'd5, 32'hFF223344, 32'hFF223344); tick();

      // T4: different-address simultaneous write and read
      wr(3'd4, 32'h0000005A, 4'b1111); tick();
      wr(3'd1, 32'h12345678, 4'b1111);
      rd(3'd4, 32'h0000005A, 32'h0000005A); tick();
      rd(3'd1, 32'h12345678, 32'h12345678); tick();
      check_err("t4", 1'b0, 2'd0);

      // T5: out-of-range write and read together; WR_OOR has priority and sticks
      wr(3'd7, 32'hDEADBEEF, 4'b1111);
      rd_en = 1'b1; rd_addr = 3'd6;
      tick();
      check("t5_rd_vld_a", {31'd0, rd_vld_a}, 32'd0);
      check("t5_rd_data_a", rd_data_a, 32'd0);
      check_err("t5_oor", 1'b1, 2'd1);
      rd(3'd0, 32'd0, 32'd0); tick();
      check_err("t5_sticky", 1'b1, 2'd1);
      rd(3'd1, 32'h12345678, 32'h12345678); tick();
      rd(3'd5, 32'hFF223344, 32'hFF223344); tick();

      // Collision on an uninitialised entry: valid after merge only with bypass
      err_clr = 1'b1; tick();
      wr(3'd3, 32'h000000AB, 4'b0001);
      rd(3'd3, 32'h000000AB, 32'd0); tick();
      check("col_uninit_err_a", {31'd0, err_a}, 32'd0);
      check("col_uninit_code_b", {30'd0, code_b}, 32'd3);
      err_clr = 1'b1; tick();

      // wr_be=0 is a silent no-op; entry 0 stays uninitialised
      wr(3'd0, 32'hFFFFFFFF, 4'b0000); tick();
      check_err("be0_noerr", 1'b0, 2'd0);
      rd(3'd0, 32'd0, 32'd0); tick();
      check_err("be0_uninit", 1'b1, 2'd3);

      // T6: clear and new RD_OOR in the same cycle -> new error wins
      err_clr = 1'b1; rd_en = 1'b1; rd_addr = 3'd6; tick();
      check_err("t6_clr_new", 1'b1, 2'd2);

      // Reset during traffic clears outputs and contents, ignores requests
      rd(3'd1, 32'h12345678, 32'h12345678); tick();
      wr(3'd1, 32'hCAFEF00D, 4'b1111);
      rd_en = 1'b1; rd_addr = 3'd1;
      resetn = 1'b0;
      tick();
      check("rst_rd_vld_b", {31'd0, rd_vld_b}, 32'd0);
      check("rst_rd_data_b", rd_data_b, 32'd0);
      check_err("rst_mid", 1'b0, 2'd0);
      resetn = 1'b1;
      rd(3'd1, 32'd0, 32'd0); tick();
      check_err("post_rst_uninit", 1'b1, 2'd3);

      repeat (3) tick();
      check("qa_drained", qa.size(), 32'd0);
      check("qb_drained", qb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
